load_store_unit: RTL and testbench

- Initiator-side load/store unit between the pipeline MEM stage and the byte-addressed data memory.
- Memory characteristics: combinational 64-bit little-endian read on mem_read; 8-byte write at posedge clk on mem_write.
- Accepts byte, half, word and doubleword loads and stores over a valid/ready request channel.
- Loads: sign- or zero-extended. Sub-doubleword stores: read-modify-write on the aligned doubleword. Misaligned or out-of-range accesses: flagged, no memory access issued.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a combinational-read, clocked-write data memory.
// Handles B/H/W/D loads with extension and sub-doubleword stores via read-modify-write.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned MEM_BYTES  = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [63:0]           mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e                state_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [2:0]            offset_q;
  logic [63:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [63:0]           mem_wdata_q;
  logic [63:0]           rdata_q;
  logic                  err_q;

  logic [3:0]            nbytes;
  logic [2:0]            align_mask;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  req_err;
  logic [5:0]            shamt;
  logic [63:0]           shifted;
  logic [63:0]           load_val;
  logic [63:0]           lane_mask;
  logic [63:0]           byte_mask;
  logic [63:0]           merged;

  // Request decode: alignment and range checks on the incoming address.
  always_comb begin
    nbytes     = 4'd1 << req_size;
    align_mask = 3'b000;
    unique case (req_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      2'd3: align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
    // One extra bit so addresses near the top of the space cannot wrap into range.
    end_addr = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(nbytes);
    req_err  = (|(req_addr[2:0] & align_mask)) ||
               (end_addr > (ADDR_WIDTH + 1)'(MEM_BYTES));
  end

  // Lane extraction for loads and byte merge for sub-doubleword stores.
  always_comb begin
    shamt     = {offset_q, 3'b000};
    shifted   = mem_read_data >> shamt;
    load_val  = 64'd0;
    lane_mask = 64'd0;
    unique case (size_q)
      2'd0: begin
        load_val  = unsigned_q ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
        lane_mask = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        load_val  = unsigned_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        lane_mask = 64'h0000_0000_0000_FFFF;
      end
      2'd2: begin
        load_val  = unsigned_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        lane_mask = 64'h0000_0000_FFFF_FFFF;
      end
      2'd3: begin
        load_val  = shifted;
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      default: begin
        load_val  = 64'd0;
        lane_mask = 64'd0;
      end
    endcase
    byte_mask = lane_mask << shamt;
    merged    = (mem_read_data & ~byte_mask) | ((wdata_q << shamt) & byte_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      offset_q    <= 3'd0;
      wdata_q     <= 64'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 64'd0;
      rdata_q     <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            offset_q   <= req_addr[2:0];
            wdata_q    <= req_wdata;
            if (req_err) begin
              rdata_q <= 64'd0;
              err_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              err_q      <= 1'b0;
              mem_addr_q <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
              if (req_write && req_size == 2'd3) begin
                mem_wdata_q <= req_wdata;
                state_q     <= StWrite;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StRead: begin
          if (write_q) begin
            mem_wdata_q <= merged;
            state_q     <= StWrite;
          end else begin
            rdata_q <= load_val;
            err_q   <= 1'b0;
            state_q <= StResp;
          end
        end
        StWrite: begin
          rdata_q <= 64'd0;
          err_q   <= 1'b0;
          state_q <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign mem_read       = (state_q == StRead);
  assign mem_write      = (state_q == StWrite);
  assign resp_valid     = (state_q == StResp);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven through a scoreboard queue,
// plus hand-written backpressure and reset-during-write sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_read_data;

  logic        load_mem;
  logic [63:0] mem [8];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [63:0] exp_mwdata;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  load_store_unit #(.ADDR_WIDTH(64), .MEM_BYTES(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[5:3]];

  always @(posedge clk) begin
    if (load_mem) begin
      mem[0] <= 64'h4;
      mem[1] <= 64'h40;
      mem[2] <= 64'h5;
      mem[3] <= 64'h50;
      mem[4] <= 64'h0;
      mem[5] <= 64'h100;
      mem[6] <= 64'h0;
      mem[7] <= 64'h8000_1234_5678_9ABC;
    end else if (mem_write) begin
      mem[mem_addr[5:3]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic u,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [63:0] rd, input logic er, input int lat,
                              input int nr, input int nw, input logic [63:0] mw);
    vec_t v;
    v.wr = wr; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_err = er; v.exp_lat = lat;
    v.exp_rd = nr; v.exp_wr = nw; v.exp_mwdata = mw;
    return v;
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input vec_t v, input int hold);
    vec_t        e;
    int          lat;
    int          nrd;
    int          nwr;
    bit          got;
    logic [63:0] rd_addr;
    logic [63:0] wr_addr;
    logic [63:0] wd;
    logic [63:0] aligned;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_valid    = 1'b1;
    sb.push_back(v);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = {32'd0, $urandom};
    req_wdata = {$urandom, $urandom};
    lat = 1; nrd = 0; nwr = 0; got = 0;
    rd_addr = '0; wr_addr = '0; wd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_read) begin nrd++; rd_addr = mem_addr; end
      if (mem_write) begin nwr++; wr_addr = mem_addr; wd = mem_write_data; end
      if (resp_valid) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got no resp_valid want resp_valid for addr %h", e.addr);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      return;
    end
    aligned = {e.addr[63:3], 3'b000};
    chk("resp_rdata", resp_rdata, e.exp_rdata);
    chk("resp_err", {63'd0, resp_err}, {63'd0, e.exp_err});
    chk("latency", 64'(lat), 64'(e.exp_lat));
    chk("mem_read_cycles", 64'(nrd), 64'(e.exp_rd));
    chk("mem_write_cycles", 64'(nwr), 64'(e.exp_wr));
    if (e.exp_rd > 0) chk("mem_addr_read", rd_addr, aligned);
    if (e.exp_wr > 0) begin
      chk("mem_addr_write", wr_addr, aligned);
      chk("mem_write_data", wd, e.exp_mwdata);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_resp_rdata", resp_rdata, e.exp_rdata);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("idle_after_resp", {62'd0, req_ready, resp_valid}, 64'd2);
  endtask

  initial begin
    reset_n      = 1'b0;
    load_mem     = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 64'd0;
    req_wdata    = 64'd0;
    resp_ready   = 1'b0;

    vecs.push_back(mk(0, 2'd3, 0, 64'd8,  64'd0, 64'h40, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(1, 2'd0, 0, 64'd16, 64'hF0, 64'd0, 0, 3, 1, 1, 64'hF0));
    vecs.push_back(mk(0, 2'd0, 0, 64'd16, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd0, 1, 64'd16, 64'd0, 64'hF0, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(1, 2'd1, 0, 64'd2,  64'hBEEF, 64'd0, 0, 3, 1, 1, 64'h0000_0000_BEEF_0004));
    vecs.push_back(mk(0, 2'd2, 0, 64'd0,  64'd0, 64'hFFFF_FFFF_BEEF_0004, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd2, 1, 64'd0,  64'd0, 64'h0000_0000_BEEF_0004, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd2, 0, 64'd6,  64'd0, 64'd0, 1, 1, 0, 0, 64'd0));
    vecs.push_back(mk(0, 2'd3, 0, 64'd64, 64'd0, 64'd0, 1, 1, 0, 0, 64'd0));
    vecs.push_back(mk(1, 2'd3, 0, 64'd48, 64'h1122_3344_5566_7788, 64'd0, 0, 2, 0, 1,
                      64'h1122_3344_5566_7788));
    vecs.push_back(mk(0, 2'd3, 0, 64'd48, 64'd0, 64'h1122_3344_5566_7788, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd1, 1, 64'd62, 64'd0, 64'h8000, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd1, 0, 64'd62, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(1, 2'd2, 0, 64'd60, 64'hFFFF_FFFF_CAFE_F00D, 64'd0, 0, 3, 1, 1,
                      64'hCAFE_F00D_5678_9ABC));
    vecs.push_back(mk(0, 2'd3, 0, 64'd56, 64'd0, 64'hCAFE_F00D_5678_9ABC, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(0, 2'd0, 0, 64'd63, 64'd0, 64'hFFFF_FFFF_FFFF_FFCA, 0, 2, 1, 0, 64'd0));
    vecs.push_back(mk(1, 2'd1, 0, 64'd63, 64'h1234, 64'd0, 1, 1, 0, 0, 64'd0));
    vecs.push_back(mk(1, 2'd0, 0, 64'd64, 64'h55, 64'd0, 1, 1, 0, 0, 64'd0));

    @(posedge clk);
    @(posedge clk);
    #1 load_mem = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_flags", {60'd0, resp_valid, resp_err, mem_read, mem_write}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_txn(vecs[i], 0);

    // Response backpressure: data must sit still while resp_ready is low.
    run_txn(mk(0, 2'd3, 0, 64'd24, 64'd0, 64'h50, 0, 2, 1, 0, 64'd0), 3);

    // Doubleword store to 40, killed by reset while in WRITE before its commit edge.
    req_write    = 1'b1;
    req_size     = 2'd3;
    req_unsigned = 1'b0;
    req_addr     = 64'd40;
    req_wdata    = 64'hDEAD_BEEF;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_in_write", {63'd0, mem_write}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_write_drop", {63'd0, mem_write}, 64'd0);
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(mk(0, 2'd3, 0, 64'd40, 64'd0, 64'h100, 0, 2, 1, 0, 64'd0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test want completion");
    $fatal(1);
  end

endmodule
